// File: rtl/key_matrix_emu.sv
// Responder end of a 4x4 column-scan keypad: emulates one key held at a time,
// with LFSR-driven contact bounce on make and break.
module key_matrix_emu #(
  parameter int T1ms       = 50_000,
  parameter int BOUNCE_MS  = 5,
  parameter int BOUNCE_DIV = 997
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [7:0] cmd_hold_ms,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       done
);

  localparam int TICK_W = (T1ms > 1) ? $clog2(T1ms) : 1;
  localparam int DIV_W  = (BOUNCE_DIV > 1) ? $clog2(BOUNCE_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(T1ms - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BOUNCE_DIV - 1);
  localparam logic [7:0]        BMS_LAST  = 8'(BOUNCE_MS - 1);
  localparam logic [15:0]       LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT} state_t;

  state_t            state;
  logic [TICK_W-1:0] tick;
  logic [7:0]        ms;
  logic [DIV_W-1:0]  div;
  logic [15:0]       lfsr;
  logic [3:0]        key;
  logic [7:0]        hold_last;
  logic [7:0]        phase_last;
  logic              ms_wrap;
  logic              phase_end;
  logic              bouncing;
  logic              contact;
  logic              accept;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign accept    = cmd_valid && cmd_ready;
  assign bouncing  = (state == BOUNCE_IN) || (state == BOUNCE_OUT);
  assign ms_wrap   = (tick == TICK_LAST);
  assign phase_end = ms_wrap && (ms == phase_last);
  assign contact   = (state == HOLD) || (bouncing && lfsr[0]);

  always_comb begin
    phase_last = BMS_LAST;
    if (state == HOLD)
      phase_last = hold_last;
  end

  // Passive switch: only the latched row can be pulled low, and only by its column.
  always_comb begin
    row = 4'b1111;
    row[key[3:2]] = col[key[1:0]] | ~contact;
  end

  // Key and hold time are plain data, captured on accept and never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      key       <= cmd_key;
      hold_last <= (cmd_hold_ms == 8'd0) ? 8'd0 : cmd_hold_ms - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      tick      <= '0;
      ms        <= '0;
      div       <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      done <= 1'b0;
      tick <= ms_wrap ? '0 : tick + 1'b1;
      if (ms_wrap)
        ms <= ms + 8'd1;

      // The bounce divider only counts bounce cycles, so the pattern is reproducible.
      if (bouncing) begin
        if (div == DIV_LAST) begin
          div  <= '0;
          lfsr <= lfsr_step(lfsr);
        end else begin
          div <= div + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          tick <= '0;
          ms   <= '0;
          if (accept) begin
            state     <= (BOUNCE_MS == 0) ? HOLD : BOUNCE_IN;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        BOUNCE_IN: begin
          if (phase_end) begin
            state <= HOLD;
            tick  <= '0;
            ms    <= '0;
          end
        end
        HOLD: begin
          if (phase_end) begin
            tick <= '0;
            ms   <= '0;
            if (BOUNCE_MS == 0) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              done      <= 1'b1;
            end else begin
              state <= BOUNCE_OUT;
            end
          end
        end
        BOUNCE_OUT: begin
          // busy stays high through the done cycle so back-to-back presses look continuous.
          if (phase_end) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
            tick      <= '0;
            ms        <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/key_matrix_emu.md
# key_matrix_emu

Synthesizable 4x4 keypad matrix emulator: the responder end of the key_pad column-scan interface. It takes the `col` scan lines driven by the key_pad scanner and drives the `row` return lines exactly as a physical keypad would while one emulated key is held. A command port schedules each press, with contact bounce on make and break, so scanner/debounce logic can be exercised on-board or in a self-checking bench without a real keypad.

## Interface
- `T1ms`, 50_000: clock cycles per millisecond.
- `BOUNCE_MS`, 5: bounce window length in ms on both press and release; 0 disables bounce.
- `BOUNCE_DIV`, 997: cycles between LFSR advances during bounce; must be ≥1.

- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: press command offered.
- `cmd_ready` output 1: emulator idle, command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_key` input 4: key code; row index = `cmd_key[3:2]`, column index = `cmd_key[1:0]`.
- `cmd_hold_ms` input 8: stable-closed time in ms; 0 treated as 1.
- `col` input 4: scan columns from the scanner, active-low.
- `row` output 4: row returns to the scanner, idle-high.
- `busy` output 1: a press is in progress (not IDLE).
- `done` output 1: one-cycle pulse when a press sequence completes.

## Operation
- FSM states: IDLE → BOUNCE_IN → HOLD → BOUNCE_OUT → IDLE.
- IDLE: `cmd_ready`=1, contact open. On accept, latch key and hold_ms (0→1), clear counters, go to BOUNCE_IN. If BOUNCE_MS=0, go directly to HOLD.
- BOUNCE_IN: lasts BOUNCE_MS·T1ms cycles. Contact = `lfsr[0]`. Then go to HOLD.
- HOLD: lasts hold_ms·T1ms cycles. Contact closed. Then go to BOUNCE_OUT, or to IDLE if BOUNCE_MS=0.
- BOUNCE_OUT: lasts BOUNCE_MS·T1ms cycles. Contact = `lfsr[0]`. Then go to IDLE.
- Timebase:
  - tick counter runs 0..T1ms-1 and wraps.
  - ms counter increments on wrap.
  - Both counters clear on every state change.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Seed 16'hACE1 on reset.
  - Advances once every BOUNCE_DIV cycles, only while in a bounce state, and holds otherwise.
  - The sequence is deterministic from reset.
- Row mapping (combinational, models a passive switch):
  - `row[r] = 1` for every r ≠ latched row.
  - `row[latched_row] = col[latched_col] | ~contact`.
  - Contact open gives `row` = 4'b1111 regardless of `col`.
- Commands offered while busy are ignored, because `cmd_ready`=0. `cmd_valid` may stay asserted; it is accepted on the first IDLE cycle.
- Only one key can be emulated at a time. There is no ghosting or multi-key behaviour.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `row`=4'b1111, counters 0, LFSR 16'hACE1.
- Reset asserted mid-press: released at the next edge, so `row` is 4'b1111 the following cycle. No `done` pulse is generated.
- Accept edge at cycle N:
  - `busy`=1 and `cmd_ready`=0 from cycle N+1.
  - First BOUNCE_IN cycle is N+1.
- Total press length: (2·BOUNCE_MS + hold_ms)·T1ms cycles.
- `done`=1 in the first IDLE cycle after the sequence. `cmd_ready`=1 in that same cycle, so back-to-back commands are accepted with zero gap cycles.
- `col`→`row` has zero-cycle latency (combinational). All other outputs are registered.
- Counter widths: tick counter ≥ clog2(T1ms); ms counter 8 bits (hold max 255 ms, BOUNCE_MS ≤ 255).

## Test plan
Common configuration for all scenarios: T1ms=50, BOUNCE_MS=2, BOUNCE_DIV=7.

- Reset: hold `rst` 3 cycles with `col` toggling → `row`=4'b1111, `cmd_ready`=1, `busy`=0, `done`=0 throughout.
- Key 0x9, hold 5 ms, `col` driven 4'b1101 constant:
  - `row`=4'b1011 during all 250 HOLD cycles.
  - `row[2]` varies during both 100-cycle bounce windows.
  - `done` pulses exactly 450 cycles after the accept edge.
- Key 0xF with real key_pad scanner as the `col` driver → scanner `flag` pulses once with `data`=4'hF.
- Key 0x0, hold 0 → treated as 1 ms; `done` at 250 cycles after accept.
- Back-to-back commands, `cmd_valid` held high with keys 0xA then 0xB:
  - Second accept occurs in the `done` cycle.
  - A third `cmd_valid` while busy is ignored.
  - `busy` stays 1 continuously across both presses.
- `rst` pulse in mid-HOLD → `row`=4'b1111 next cycle, no `done` pulse, `cmd_ready`=1.
